// File: rtl/capture_mux_rr.sv
// Packet-aware N:1 stream multiplexer. A channel holds the output from its first
// beat to its EOP. Beats pass through a 2-entry skid buffer, with a packet counter and a framing check.
module capture_mux_rr #(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = 32,
  parameter  int ARB_MODE = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int EMPTY_W  = ((DATA_W / 8) > 1) ? $clog2(DATA_W / 8) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*DATA_W-1:0]  in_data,
  input  logic [NUM_CH-1:0]         in_startofpacket,
  input  logic [NUM_CH-1:0]         in_endofpacket,
  input  logic [NUM_CH*EMPTY_W-1:0] in_empty,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_startofpacket,
  output logic                      out_endofpacket,
  output logic [EMPTY_W-1:0]        out_empty,
  output logic [CH_W-1:0]           out_channel,
  output logic [31:0]               pkt_count,
  output logic                      err_framing
);

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  state_e          state_q, state_d;
  logic [CH_W-1:0] grant_q, grant_d;
  logic [CH_W-1:0] last_grant_q, last_grant_d;
  logic            in_pkt_q, in_pkt_d;
  logic            err_q, err_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;

  beat_t           buf_q [2];
  beat_t           buf_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            buf_ready_q, buf_ready_d;

  beat_t           sel_beat;
  beat_t           head;
  logic            accept;
  logic            pop;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (int'(ch) == NUM_CH - 1) ? '0 : ch + CH_W'(1);
  endfunction

  // Round-robin scans upward from base with wrap-around; fixed priority ignores base.
  function automatic logic [CH_W-1:0] arbitrate(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   base);
    logic [CH_W-1:0] win;
    logic [CH_W-1:0] idx;
    logic            found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == 1) ? CH_W'(k) : CH_W'((int'(base) + k) % NUM_CH);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    sel_beat.ch    = grant_q;
    sel_beat.data  = in_data[int'(grant_q)*DATA_W +: DATA_W];
    sel_beat.sop   = in_startofpacket[grant_q];
    sel_beat.eop   = in_endofpacket[grant_q];
    sel_beat.empty = in_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
  end

  always_comb begin
    in_ready = '0;
    if (state_q == ST_LOCKED) in_ready[grant_q] = buf_ready_q;
  end

  assign accept = (state_q == ST_LOCKED) && in_valid[grant_q] && buf_ready_q;
  assign head   = buf_q[rd_ptr_q];
  assign pop    = (count_q != 2'd0) && out_ready;

  // Arbitration and framing control.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path infers a latch.
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    in_pkt_d     = in_pkt_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        in_pkt_d = 1'b0;
        if (|in_valid) begin
          grant_d = arbitrate(in_valid, next_ch(last_grant_q));
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          // First beat of a packet must carry SOP; any later beat must not.
          if (sel_beat.sop == in_pkt_q) err_d = 1'b1;
          in_pkt_d = !sel_beat.eop;
          if (sel_beat.eop) begin
            last_grant_d = grant_q;
            if (|in_valid) grant_d = arbitrate(in_valid, next_ch(grant_q));
            else           state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid buffer and packet counter.
  always_comb begin
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (accept) begin
      buf_d[wr_ptr_q] = sel_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d     = count_q + {1'b0, accept} - {1'b0, pop};
    buf_ready_d = (count_d != 2'd2);
    pkt_cnt_d   = pkt_cnt_q;
    if (pop && head.eop) pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      in_pkt_q     <= 1'b0;
      err_q        <= 1'b0;
      pkt_cnt_q    <= '0;
      // NOTE: buffer entries are reset too, because out_* read straight from them and must be zero in reset.
      for (int i = 0; i < 2; i++) buf_q[i] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      buf_ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      in_pkt_q     <= in_pkt_d;
      err_q        <= err_d;
      pkt_cnt_q    <= pkt_cnt_d;
      buf_q        <= buf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      buf_ready_q  <= buf_ready_d;
    end
  end

  assign out_valid         = (count_q != 2'd0);
  assign out_data          = head.data;
  assign out_startofpacket = head.sop;
  assign out_endofpacket   = head.eop;
  assign out_empty         = head.empty;
  assign out_channel       = head.ch;
  assign pkt_count         = pkt_cnt_q;
  assign err_framing       = err_q;

endmodule

// File: tb/tb_capture_mux_rr.sv
// Directed bench for capture_mux_rr: a round-robin instance driven from per-channel
// beat queues, and a fixed-priority instance with ch1 and ch3 both always valid.
module tb_capture_mux_rr;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 32;
  localparam int CH_W    = 2;
  localparam int EMPTY_W = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } tb_beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0]         in_valid, in_ready, in_sop, in_eop;
  logic [NUM_CH*DATA_W-1:0]  in_data;
  logic [NUM_CH*EMPTY_W-1:0] in_empty;
  logic                      out_valid, out_ready, out_sop, out_eop, err_framing;
  logic [DATA_W-1:0]         out_data;
  logic [EMPTY_W-1:0]        out_empty;
  logic [CH_W-1:0]           out_channel;
  logic [31:0]               pkt_count;

  logic [NUM_CH-1:0]         fp_in_valid, fp_in_ready, fp_in_sop, fp_in_eop;
  logic [NUM_CH*DATA_W-1:0]  fp_in_data;
  logic [NUM_CH*EMPTY_W-1:0] fp_in_empty;
  logic                      fp_out_valid, fp_out_ready, fp_out_sop, fp_out_eop, fp_err;
  logic [DATA_W-1:0]         fp_out_data;
  logic [EMPTY_W-1:0]        fp_out_empty;
  logic [CH_W-1:0]           fp_out_channel;
  logic [31:0]               fp_pkt_count;

  capture_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_empty(in_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty),
    .out_channel(out_channel), .pkt_count(pkt_count), .err_framing(err_framing)
  );

  capture_mux_rr #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ARB_MODE(1)) dut_fp (
    .clk(clk), .reset(reset),
    .in_valid(fp_in_valid), .in_ready(fp_in_ready), .in_data(fp_in_data),
    .in_startofpacket(fp_in_sop), .in_endofpacket(fp_in_eop), .in_empty(fp_in_empty),
    .out_valid(fp_out_valid), .out_ready(fp_out_ready), .out_data(fp_out_data),
    .out_startofpacket(fp_out_sop), .out_endofpacket(fp_out_eop), .out_empty(fp_out_empty),
    .out_channel(fp_out_channel), .pkt_count(fp_pkt_count), .err_framing(fp_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  tb_beat_t          src_q [NUM_CH][$];
  logic [NUM_CH-1:0] hold;
  logic [CH_W-1:0]   obs_ch   [$];
  logic [31:0]       obs_data [$];
  int                obs_cyc  [$];
  logic [31:0]       obs_pkt  [$];
  int                cyc = 0;
  logic              prev_stall;
  logic [38:0]       prev_out;
  int                unstable;
  int                fp_xfer = 0, fp_ch1 = 0, fp_ch3 = 0;

  task automatic drive_sources();
    tb_beat_t b;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_q[c].size() != 0 && !hold[c]) begin
        b = src_q[c][0];
        in_valid[c]            = 1'b1;
        in_data[c*DATA_W +: DATA_W] = b.data;
        in_sop[c]              = b.sop;
        in_eop[c]              = b.eop;
      end else begin
        in_valid[c]            = 1'b0;
        in_data[c*DATA_W +: DATA_W] = '0;
        in_sop[c]              = 1'b0;
        in_eop[c]              = 1'b0;
      end
    end
  endtask

  task automatic add_beat(input int ch, input logic [31:0] data, input logic sop, input logic eop);
    tb_beat_t b;
    b.data = data;
    b.sop  = sop;
    b.eop  = eop;
    src_q[ch].push_back(b);
  endtask

  task automatic add_pkt(input int ch, input int nbeats, input logic [31:0] base);
    for (int i = 0; i < nbeats; i++)
      add_beat(ch, base + 32'(i), (i == 0), (i == nbeats - 1));
  endtask

  task automatic clear_obs();
    obs_ch.delete();
    obs_data.delete();
    obs_cyc.delete();
    obs_pkt.delete();
    prev_stall = 1'b0;
    unstable   = 0;
  endtask

  // One clock: sample handshakes at the falling edge, retire accepted beats after the rising edge.
  task automatic tick();
    logic [NUM_CH-1:0] acc;
    @(negedge clk);
    if (prev_stall && ({out_valid, out_channel, out_data, out_sop, out_eop, out_empty} !== prev_out))
      unstable++;
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_valid, out_channel, out_data, out_sop, out_eop, out_empty};
    if (out_valid && out_ready) begin
      obs_ch.push_back(out_channel);
      obs_data.push_back(out_data);
      obs_cyc.push_back(cyc);
      obs_pkt.push_back(pkt_count);
    end
    if (fp_out_valid && fp_out_ready) begin
      fp_xfer++;
      if (fp_out_channel == 2'd1) fp_ch1++;
      if (fp_out_channel == 2'd3) fp_ch3++;
    end
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NUM_CH; c++)
      if (acc[c]) void'(src_q[c].pop_front());
    drive_sources();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    hold      = '0;
    out_ready = 1'b1;
    drive_sources();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_obs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_d;
    int          leak;

    reset        = 1'b1;
    hold         = '0;
    out_ready    = 1'b1;
    in_empty     = '0;
    drive_sources();
    fp_in_valid  = '0;
    fp_in_sop    = '0;
    fp_in_eop    = '0;
    fp_in_data   = '0;
    fp_in_empty  = '0;
    fp_out_ready = 1'b1;
    clear_obs();

    // Values held in reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_err", err_framing, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_channel", out_channel, 0);

    // All four channels offering 2-beat packets, round-robin, no gaps.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < NUM_CH; c++)
        add_pkt(c, 2, 32'h1000_0000 + 32'(c << 8) + 32'(p << 4));
    drive_sources();
    for (int t = 0; t < 60 && obs_ch.size() < 16; t++) tick();
    check("A_beats", obs_ch.size(), 16);
    for (int i = 0; i < obs_ch.size() && i < 16; i++) begin
      exp_d = 32'h1000_0000 + 32'(((i / 2) % 4) << 8) + 32'((i / 8) << 4) + 32'(i % 2);
      check($sformatf("A_ch[%0d]", i), obs_ch[i], 64'((i / 2) % 4));
      check($sformatf("A_data[%0d]", i), obs_data[i], exp_d);
    end
    if (obs_cyc.size() >= 9) begin
      check("A_no_gap", obs_cyc[7] - obs_cyc[0], 7);
      check("A_pkt_after_8", obs_pkt[8], 4);
    end
    check("A_pkt_total", pkt_count, 8);
    check("A_err", err_framing, 0);

    // Granted channel stalls mid-packet; others stay blocked until it finishes.
    do_reset();
    add_pkt(1, 3, 32'h2000_0010);
    drive_sources();
    for (int t = 0; t < 20 && src_q[1].size() == 3; t++) tick();
    check("B_ch1_started", src_q[1].size(), 2);
    add_pkt(0, 1, 32'h2000_0000);
    add_pkt(2, 1, 32'h2000_0020);
    hold[1] = 1'b1;
    drive_sources();
    leak = 0;
    repeat (5) begin
      if (in_ready[0] || in_ready[2]) leak++;
      tick();
    end
    check("B_others_stalled", leak, 0);
    hold[1] = 1'b0;
    drive_sources();
    for (int t = 0; t < 40 && obs_ch.size() < 5; t++) tick();
    check("B_beats", obs_ch.size(), 5);
    if (obs_ch.size() == 5) begin
      check("B_ch0", obs_ch[0], 1);
      check("B_ch2", obs_ch[2], 1);
      check("B_data2", obs_data[2], 32'h2000_0012);
      check("B_ch3", obs_ch[3], 2);
      check("B_ch4", obs_ch[4], 0);
    end

    // Single-beat packets on ch2 with out_ready toggling.
    do_reset();
    for (int k = 0; k < 6; k++) add_pkt(2, 1, 32'hC0DE_0000 + 32'(k));
    drive_sources();
    for (int t = 0; t < 80 && obs_data.size() < 6; t++) begin
      out_ready = (t % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    check("C_beats", obs_data.size(), 6);
    for (int i = 0; i < obs_data.size(); i++)
      check($sformatf("C_data[%0d]", i), obs_data[i], 32'hC0DE_0000 + 32'(i));
    check("C_stable", unstable, 0);
    check("C_pkt", pkt_count, 6);
    check("C_err", err_framing, 0);

    // First beat without SOP flags a framing error and is still forwarded.
    do_reset();
    add_beat(0, 32'hA5A5_A5A5, 1'b0, 1'b1);
    drive_sources();
    check("D_err_before", err_framing, 0);
    for (int t = 0; t < 20 && src_q[0].size() != 0; t++) tick();
    check("D_err_set", err_framing, 1);
    repeat (4) tick();
    check("D_err_sticky", err_framing, 1);
    check("D_fwd_count", obs_data.size(), 1);
    if (obs_data.size() != 0) check("D_fwd_data", obs_data[0], 32'hA5A5_A5A5);

    // A repeated SOP inside a packet also flags the error.
    do_reset();
    add_beat(1, 32'h0000_0D01, 1'b1, 1'b0);
    add_beat(1, 32'h0000_0D02, 1'b1, 1'b1);
    drive_sources();
    for (int t = 0; t < 20 && src_q[1].size() == 2; t++) tick();
    check("D2_err_first", err_framing, 0);
    for (int t = 0; t < 20 && src_q[1].size() != 0; t++) tick();
    check("D2_err_second", err_framing, 1);

    // Reset mid-packet clears everything at once; arbitration restarts from ch0.
    do_reset();
    out_ready = 1'b0;
    add_pkt(2, 4, 32'hE000_0000);
    drive_sources();
    for (int t = 0; t < 20 && src_q[2].size() > 3; t++) tick();
    check("E_pre_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("E_rst_valid", out_valid, 0);
    check("E_rst_data", out_data, 0);
    check("E_rst_channel", out_channel, 0);
    check("E_rst_in_ready", in_ready, 0);
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    out_ready = 1'b1;
    add_pkt(3, 1, 32'hE300_0000);
    add_pkt(1, 1, 32'hE100_0000);
    drive_sources();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_obs();
    check("E_pkt_after", pkt_count, 0);
    for (int t = 0; t < 20 && obs_ch.size() < 2; t++) tick();
    check("E_beats", obs_ch.size(), 2);
    if (obs_ch.size() == 2) begin
      check("E_first_grant", obs_ch[0], 1);
      check("E_second_grant", obs_ch[1], 3);
    end

    // Fixed priority: ch1 always beats ch3.
    fp_in_valid = 4'b1010;
    fp_in_sop   = 4'b1010;
    fp_in_eop   = 4'b1010;
    fp_in_data[1*DATA_W +: DATA_W] = 32'h1111_1111;
    fp_in_data[3*DATA_W +: DATA_W] = 32'h3333_3333;
    repeat (30) tick();
    check("F_flowing", fp_xfer > 20, 1);
    check("F_ch3_never", fp_ch3, 0);
    check("F_ch1_all", fp_ch1, fp_xfer);
    check("F_pkt", fp_pkt_count, 32'(fp_xfer));
    check("F_err", fp_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/capture_mux_rr.md
CAPTURE_MUX_RR -- requirements
Module: capture_mux_rr

Interface
REQ-001 Parameters SHALL be:
  NUM_CH, 4, number of input channels (2..16).
  DATA_W, 32, data bits per beat (8..256, multiple of 8).
  ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
  CH_W, derived max(1, clog2(NUM_CH)), channel field width.
  EMPTY_W, derived max(1, clog2(DATA_W/8)), empty field width.
REQ-002 Ports SHALL be:
  clk  in  1  single clock, all logic rising-edge.
  reset  in  1  asynchronous, active-high reset.
  in_valid  in  NUM_CH  per-channel valid.
  in_ready  out  NUM_CH  per-channel ready.
  in_data  in  NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W].
  in_startofpacket  in  NUM_CH  per-channel SOP.
  in_endofpacket  in  NUM_CH  per-channel EOP.
  in_empty  in  NUM_CH*EMPTY_W  per-channel empty symbols.
  out_valid  out  1  output valid.
  out_ready  in  1  output ready.
  out_data  out  DATA_W  output data.
  out_startofpacket  out  1  output SOP.
  out_endofpacket  out  1  output EOP.
  out_empty  out  EMPTY_W  output empty.
  out_channel  out  CH_W  source channel of the current output beat.
  pkt_count  out  32  number of packets completed on the output.
  err_framing  out  1  sticky framing-error flag.

Function
REQ-003 States SHALL be IDLE and LOCKED, with a registered grant (CH_W) and a registered last_grant.
REQ-004 In IDLE, when any in_valid=1, grant SHALL load the arbitration winner and the state SHALL become LOCKED on the next edge; in_ready SHALL be 0 for every channel in IDLE.
REQ-005 In ARB_MODE 0, the search SHALL start at (last_grant+1) mod NUM_CH and proceed upward with wrap-around; in ARB_MODE 1, the lowest valid index SHALL win.
REQ-006 In LOCKED, in_ready[grant] SHALL equal buf_ready and all other in_ready bits SHALL be 0.
REQ-007 A beat SHALL be accepted when in_valid[grant] && in_ready[grant].
REQ-008 While LOCKED with in_valid[grant]=0, the block SHALL remain LOCKED on grant; other channels stay stalled and there is no timeout.
REQ-009 On an accepted beat with EOP:
  last_grant SHALL load grant.
  Arbitration SHALL rerun in the same cycle, excluding nothing and using the updated RR base (grant+1).
  If any in_valid=1, including the just-finished channel, grant SHALL load the winner and the state stays LOCKED; otherwise the state SHALL become IDLE.
  Back-to-back packets therefore incur zero idle cycles.
REQ-010 The output stage SHALL be a 2-entry skid buffer holding {grant, data, sop, eop, empty}.
  buf_ready SHALL be registered and equal 1 when fewer than 2 entries are held.
  A beat accepted at edge N SHALL appear on out_* after edge N.
  Sustained throughput SHALL be 1 beat/clk when out_ready=1.
REQ-011 out_* SHALL hold stable while out_valid=1 && out_ready=0; no beat may be dropped or duplicated.
REQ-012 pkt_count SHALL increment by 1 on each output transfer with out_endofpacket=1, wrapping from 2^32-1 to 0.
REQ-013 err_framing SHALL set, and hold until reset, when either condition occurs:
  The first accepted beat after a grant change or IDLE has SOP=0.
  A later beat within the packet has SOP=1.
  The offending beat SHALL still be forwarded unchanged.
REQ-014 A single-beat packet (SOP=EOP=1) SHALL be legal and SHALL count as one packet.

Reset
REQ-015 While reset=1, asynchronously:
  State SHALL be IDLE, grant SHALL be 0, and last_grant SHALL be NUM_CH-1.
  The buffer SHALL be empty, with buf_ready=0 during reset and 1 from the first edge after release.
  out_valid, out_data, out_startofpacket, out_endofpacket, out_empty, out_channel, pkt_count, err_framing and in_ready SHALL all be 0.
REQ-016 Reset asserted mid-packet SHALL discard the partial packet and buffered beats; after release, arbitration SHALL restart from channel 0 in RR mode.

Verification
REQ-017 NUM_CH=4, ARB_MODE=0, out_ready=1, all channels continuously offering 2-beat packets -> out_channel order 0,0,1,1,2,2,3,3,0,...; no gap cycles; pkt_count=4 after 8 beats.
REQ-018 Ch1 is mid-packet (SOP sent) and ch1 valid deasserts for 5 clks while ch0 and ch2 are valid -> in_ready[0]=in_ready[2]=0 throughout; ch1 completes before any other channel is granted.
REQ-019 Continuous single-beat packets on ch2, out_ready toggling 1,0,1,0 -> every data word appears exactly once in order; out_* is stable during out_ready=0 cycles; pkt_count equals the number of transfers.
REQ-020 ARB_MODE=1, ch3 and ch1 both always valid -> ch1 wins every arbitration; ch3 is never granted while ch1 remains valid.
REQ-021 Ch0 sends a first beat with SOP=0, data 0xA5A5A5A5 -> err_framing=1 one clk after acceptance and stays 1; beat appears on output with data 0xA5A5A5A5.
REQ-022 Reset asserted on beat 2 of a 4-beat packet -> all outputs 0 immediately; after release, the next grant goes to the lowest valid channel; pkt_count=0.
